router_pkt_reg: RTL and testbench
=================================

// Module: router_pkt_reg
// PURPOSE
//  Parametrised packet register stage between the router input and the per-channel FIFOs.
//  Self-sequenced by an internal FSM; no external state decode.
//  Parses the header and checks address and declared length.
//  Accumulates XOR parity and forwards header, payload and parity to the selected channel.
//  Buffers one beat in a skid entry so the upstream can be stalled cleanly while the FIFO is full.
// PARAMETERS
//  DATA_WIDTH  8  beat width; header = {len[DATA_WIDTH-1:ADDR_BITS], addr[ADDR_BITS-1:0]}
//  ADDR_BITS   2  width of the destination address field
//  NUM_CH      3  number of destination channels; legal addr is 0..NUM_CH-1, and NUM_CH <= 2**ADDR_BITS
// PORTS
//  clock       in   1            sole clock, rising edge
//  reset       in   1            synchronous, active-high
//  in_valid    in   1            upstream beat valid
//  in_last     in   1            qualifies the parity (final) beat of a packet
//  data_in     in   DATA_WIDTH   upstream beat
//  in_ready    out  1            registered; beat accepted when in_valid & in_ready
//  dout        out  DATA_WIDTH   beat to the channel FIFOs
//  dout_valid  out  1            dout holds a beat
//  dout_last   out  1            dout is the parity beat
//  dout_ready  in   1            FIFO can accept (~fifo_full); transfer = dout_valid & dout_ready
//  dest_sel    out  NUM_CH       one-hot write enable, held from header through parity beat
//  parity_done out  1            1-cycle pulse, cycle after a forwarded packet's parity beat is accepted
//  err         out  1            parity mismatch of last packet; valid with parity_done
//  len_err     out  1            beat count mismatch of last packet; valid with parity_done
//  addr_err    out  1            1-cycle pulse: header addr >= NUM_CH, packet being dropped
// BEHAVIOUR
//  Reset: all outputs 0 except in_ready = 1; FSM = S_HDR; parity acc, beat count and skid cleared.
//  FSM transitions:
//  - S_HDR: accepted header with legal addr -> S_PAY.
//    It latches len, sets dest_sel = 1<<addr, acc = header, cnt = 0 and forwards the header.
//  - S_HDR: accepted header with illegal addr -> S_DROP.
//    It pulses addr_err next cycle; nothing is forwarded and dest_sel stays 0.
//  - S_HDR: header with in_last = 1 -> treated as payload-less. len_err is set and parity_done pulses.
//  - S_PAY: each non-last beat: acc ^= beat, cnt++ (saturating at 2**(DATA_WIDTH-ADDR_BITS)-1).
//  - S_PAY: last beat is forwarded with dout_last = 1.
//    Next cycle: parity_done = 1, err = (acc != beat), len_err = (cnt != len) | (len == 0); then -> S_HDR.
//  - S_DROP: consumes beats with in_ready held 1 until in_last, then -> S_HDR. No parity_done.
//  err/len_err hold until the next legal header is accepted, then clear.
//  Datapath buffering: output register plus one skid entry.
//  - Latency: beat accepted at cycle N appears on dout at N+1 if the output register is free.
//  - dout_valid & ~dout_ready & accept -> beat enters skid; in_ready = 0 from the next cycle.
//  - Skid drains to dout on the first transfer cycle; in_ready = 1 the cycle after.
//  - Transfer and accept in the same cycle with an empty skid -> new beat loads dout directly; no bubble.
//  - Beat order is strictly preserved. dest_sel changes only when the output register and skid are both empty.
//    A header arriving while the previous packet's last beat is still buffered is stalled (in_ready = 0).
//  in_valid = 0 mid-packet: state holds indefinitely; no timeout.
//  Reset mid-packet: the packet is discarded and buffered beats are lost; the next beat is treated as a header.
// CONFIGURATION
//  ROUTER_PKT_REG_ERR_CNT_EN defined: adds output err_count [15:0].
//  - Increments once per packet with err | len_err, and once per addr_err; saturates at 16'hFFFF.
//  - Cleared by reset.
//  Undefined: err_count port and counter logic are absent; all other behaviour is identical.
// TESTING
//  - Reset: assert reset 2 cycles with in_valid = 1 -> dout_valid = 0, in_ready = 1, all flags 0.
//  - Good packet: hdr 8'h0D (addr 1, len 3), payload 11, 22, 33, parity 8'h0D^11^22^33.
//    Expect dest_sel = 3'b010, 5 beats out in order, dout_last on beat 5, parity_done = 1, err = 0, len_err = 0.
//  - Bad parity: same packet with parity byte XOR 8'h01 -> parity_done = 1 with err = 1.
//    The next legal header clears err.
//  - Length error: hdr 8'h08 (addr 0, len 2), 3 payload beats then parity -> len_err = 1, err per parity.
//  - Illegal address: hdr 8'h07 (addr 3), 2 beats + last -> addr_err pulse, dout_valid never 1, no parity_done.
//    The following good packet is routed normally.
//  - Backpressure: dout_ready = 0 for 4 cycles mid-payload.
//    Expect in_ready = 0 one cycle after skid fill, no beat lost or duplicated, in_ready = 1 one cycle after drain.

Source files
------------

// File: rtl/router_pkt_reg.sv
// router_pkt_reg: packet register stage between the router input and the
// per-channel FIFOs. An internal FSM parses the header (len/addr), forwards
// header, payload and parity to the selected channel, checks XOR parity and the
// declared length, and drops packets addressed to a non-existent channel.
// The datapath is an output register plus one skid entry, so upstream can be
// stalled cleanly while the FIFO is full. Beat order is strictly preserved.
// Optional feature: define ROUTER_PKT_REG_ERR_CNT_EN to add err_count[15:0],
// a saturating count of errored packets and dropped (illegal address) packets.
module router_pkt_reg #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_BITS  = 2,
    parameter int NUM_CH     = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic                  in_last,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic                  dout_last,
    input  logic                  dout_ready,
    output logic [NUM_CH-1:0]     dest_sel,
    output logic                  parity_done,
    output logic                  err,
    output logic                  len_err,
`ifdef ROUTER_PKT_REG_ERR_CNT_EN
    output logic [15:0]           err_count,
`endif
    output logic                  addr_err
);

    localparam int LEN_W = DATA_WIDTH - ADDR_BITS;
    // One extra bit so NUM_CH == 2**ADDR_BITS is representable.
    localparam logic [ADDR_BITS:0] NUM_CH_LIM = (ADDR_BITS + 1)'(NUM_CH);

    typedef enum logic [1:0] {
        S_HDR  = 2'd0,
        S_PAY  = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t                  state_reg, state_next;

    logic [DATA_WIDTH-1:0]   dout_reg, dout_next;
    logic                    dout_last_reg, dout_last_next;
    logic                    dout_valid_reg, dout_valid_next;
    logic [DATA_WIDTH-1:0]   skid_reg, skid_next;
    logic                    skid_last_reg, skid_last_next;
    logic                    skid_valid_reg, skid_valid_next;
    logic                    in_ready_reg, in_ready_next;
    logic [NUM_CH-1:0]       dest_sel_reg, dest_sel_next;
    logic [DATA_WIDTH-1:0]   acc_reg, acc_next;
    logic [LEN_W-1:0]        cnt_reg, cnt_next;
    logic [LEN_W-1:0]        len_reg, len_next;
    logic                    parity_done_reg, parity_done_next;
    logic                    err_reg, err_next;
    logic                    len_err_reg, len_err_next;
    logic                    addr_err_reg, addr_err_next;

    logic [ADDR_BITS-1:0]    hdr_addr;
    logic [LEN_W-1:0]        hdr_len;
    logic [NUM_CH-1:0]       hdr_onehot;
    logic                    addr_legal;
    logic                    accept;
    logic                    hdr_ok;
    logic                    hdr_bad;
    logic                    pay_beat;
    logic                    fwd;
    logic                    transfer;

    // Header field decode and handshake qualifiers.
    assign hdr_addr   = data_in[ADDR_BITS-1:0];
    assign hdr_len    = data_in[DATA_WIDTH-1:ADDR_BITS];
    assign addr_legal = ({1'b0, hdr_addr} < NUM_CH_LIM);
    assign accept     = in_valid & in_ready_reg;
    assign hdr_ok     = accept & (state_reg == S_HDR) & addr_legal;
    assign hdr_bad    = accept & (state_reg == S_HDR) & ~addr_legal;
    assign pay_beat   = accept & (state_reg == S_PAY);
    assign fwd        = hdr_ok | pay_beat;
    assign transfer   = dout_valid_reg & dout_ready;

    // One-hot channel select decoded from the header address.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_dec
            localparam logic [ADDR_BITS-1:0] CH_ID = ADDR_BITS'(gi);
            assign hdr_onehot[gi] = (hdr_addr == CH_ID);
        end
    endgenerate

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= S_HDR;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next state: a header with in_last set is a complete packet by itself.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_HDR: begin
                if (hdr_ok && !in_last) begin
                    state_next = S_PAY;
                end else if (hdr_bad && !in_last) begin
                    state_next = S_DROP;
                end
            end
            S_PAY: begin
                if (accept && in_last) begin
                    state_next = S_HDR;
                end
            end
            S_DROP: begin
                if (accept && in_last) begin
                    state_next = S_HDR;
                end
            end
            default: state_next = S_HDR;
        endcase
    end

    // FSM outputs: datapath buffering, packet checks and flag updates.
    always_comb begin
        dout_next        = dout_reg;
        dout_last_next   = dout_last_reg;
        dout_valid_next  = dout_valid_reg;
        skid_next        = skid_reg;
        skid_last_next   = skid_last_reg;
        skid_valid_next  = skid_valid_reg;
        dest_sel_next    = dest_sel_reg;
        acc_next         = acc_reg;
        cnt_next         = cnt_reg;
        len_next         = len_reg;
        parity_done_next = 1'b0;
        err_next         = err_reg;
        len_err_next     = len_err_reg;
        addr_err_next    = 1'b0;

        // Output register / skid: skid only fills while dout is stalled.
        if (transfer) begin
            if (skid_valid_reg) begin
                dout_next       = skid_reg;
                dout_last_next  = skid_last_reg;
                skid_valid_next = 1'b0;
            end else if (fwd) begin
                dout_next      = data_in;
                dout_last_next = in_last;
            end else begin
                dout_valid_next = 1'b0;
            end
        end else if (!dout_valid_reg) begin
            if (fwd) begin
                dout_next       = data_in;
                dout_last_next  = in_last;
                dout_valid_next = 1'b1;
            end
        end else if (fwd) begin
            skid_next       = data_in;
            skid_last_next  = in_last;
            skid_valid_next = 1'b1;
        end

        // Packet bookkeeping.
        if (hdr_ok) begin
            dest_sel_next = hdr_onehot;
            acc_next      = data_in;
            cnt_next      = '0;
            len_next      = hdr_len;
            err_next      = 1'b0;
            len_err_next  = 1'b0;
            if (in_last) begin
                parity_done_next = 1'b1;
                len_err_next     = 1'b1;
            end
        end else if (state_reg == S_HDR && !dout_valid_next && !skid_valid_next) begin
            // Previous packet fully handed to the FIFO: release the channel.
            dest_sel_next = '0;
        end

        if (hdr_bad) begin
            addr_err_next = 1'b1;
        end

        if (pay_beat) begin
            if (!in_last) begin
                acc_next = acc_reg ^ data_in;
                if (cnt_reg != {LEN_W{1'b1}}) begin
                    cnt_next = cnt_reg + LEN_W'(1);
                end
            end else begin
                parity_done_next = 1'b1;
                err_next         = (acc_reg != data_in);
                len_err_next     = (cnt_reg != len_reg) || (len_reg == '0);
            end
        end

        // Stall on a full skid, and hold off the next header until the
        // previous packet has completely left the output stage.
        in_ready_next = !skid_valid_next &&
                        !((state_next == S_HDR) && dout_valid_next);
    end

    // Datapath and flag registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            dout_reg        <= '0;
            dout_last_reg   <= 1'b0;
            dout_valid_reg  <= 1'b0;
            skid_reg        <= '0;
            skid_last_reg   <= 1'b0;
            skid_valid_reg  <= 1'b0;
            in_ready_reg    <= 1'b1;
            dest_sel_reg    <= '0;
            acc_reg         <= '0;
            cnt_reg         <= '0;
            len_reg         <= '0;
            parity_done_reg <= 1'b0;
            err_reg         <= 1'b0;
            len_err_reg     <= 1'b0;
            addr_err_reg    <= 1'b0;
        end else begin
            dout_reg        <= dout_next;
            dout_last_reg   <= dout_last_next;
            dout_valid_reg  <= dout_valid_next;
            skid_reg        <= skid_next;
            skid_last_reg   <= skid_last_next;
            skid_valid_reg  <= skid_valid_next;
            in_ready_reg    <= in_ready_next;
            dest_sel_reg    <= dest_sel_next;
            acc_reg         <= acc_next;
            cnt_reg         <= cnt_next;
            len_reg         <= len_next;
            parity_done_reg <= parity_done_next;
            err_reg         <= err_next;
            len_err_reg     <= len_err_next;
            addr_err_reg    <= addr_err_next;
        end
    end

`ifdef ROUTER_PKT_REG_ERR_CNT_EN
    logic [15:0] err_count_reg;
    logic        err_event;

    // parity_done and addr_err never pulse in the same cycle (one accept per cycle).
    assign err_event = (parity_done_reg & (err_reg | len_err_reg)) | addr_err_reg;

    // Saturating error counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            err_count_reg <= '0;
        end else if (err_event && (err_count_reg != 16'hFFFF)) begin
            err_count_reg <= err_count_reg + 16'd1;
        end
    end

    assign err_count = err_count_reg;
`endif

    assign in_ready    = in_ready_reg;
    assign dout        = dout_reg;
    assign dout_valid  = dout_valid_reg;
    assign dout_last   = dout_last_reg;
    assign dest_sel    = dest_sel_reg;
    assign parity_done = parity_done_reg;
    assign err         = err_reg;
    assign len_err     = len_err_reg;
    assign addr_err    = addr_err_reg;

endmodule

// File: tb/tb_router_pkt_reg.sv
// Testbench for router_pkt_reg (DATA_WIDTH 8, ADDR_BITS 2, NUM_CH 3).
// Packets are modelled as whole units: every legal packet is expected to come
// out verbatim on its channel, with parity/length verdicts computed by XOR and
// beat counting; illegal packets are expected to vanish with one addr_err.
module tb_router_pkt_reg;

    logic       clock;
    logic       reset;
    logic       in_valid;
    logic       in_last;
    logic [7:0] data_in;
    logic       in_ready;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_last;
    logic       dout_ready;
    logic [2:0] dest_sel;
    logic       parity_done;
    logic       err;
    logic       len_err;
    logic       addr_err;
`ifdef ROUTER_PKT_REG_ERR_CNT_EN
    logic [15:0] err_count;
`endif

    router_pkt_reg #(.DATA_WIDTH(8), .ADDR_BITS(2), .NUM_CH(3)) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_last     (in_last),
        .data_in     (data_in),
        .in_ready    (in_ready),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .dout_last   (dout_last),
        .dout_ready  (dout_ready),
        .dest_sel    (dest_sel),
        .parity_done (parity_done),
        .err         (err),
        .len_err     (len_err),
`ifdef ROUTER_PKT_REG_ERR_CNT_EN
        .err_count   (err_count),
`endif
        .addr_err    (addr_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Observed (written only by the monitor) and expected (written only by tests).
    logic [11:0] out_q [$];
    logic [1:0]  pd_q  [$];
    int          ae_count  = 0;
    int          dv_cycles = 0;
    logic [11:0] exp_out [$];
    logic [1:0]  exp_pd  [$];
    int          exp_ae = 0;

    logic [7:0]  pay [0:15];

    logic bp_random = 1'b0;
    logic bp_force  = 1'b1;
    logic rnd_ready = 1'b1;
    assign dout_ready = bp_random ? rnd_ready : bp_force;

    always @(posedge clock) begin
        #1;
        rnd_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor: record every transfer, verdict pulse and addr_err pulse.
    always @(negedge clock) begin
        if (reset === 1'b0) begin
            if (dout_valid && dout_ready) out_q.push_back({dest_sel, dout_last, dout});
            if (parity_done) pd_q.push_back({err, len_err});
            if (addr_err) ae_count++;
            if (dout_valid) dv_cycles++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Expected outcome of one packet: header, pay[0..npay-1], parity.
    task automatic model_pkt(input logic [7:0] hdr, input int npay, input logic [7:0] par);
        int         addr;
        int         len;
        logic [2:0] sel;
        logic [7:0] x;
        addr = int'(hdr[1:0]);
        len  = int'(hdr[7:2]);
        if (addr < 3) begin
            sel = 3'b001 << addr;
            x   = hdr;
            exp_out.push_back({sel, 1'b0, hdr});
            for (int i = 0; i < npay; i++) begin
                exp_out.push_back({sel, 1'b0, pay[i]});
                x = x ^ pay[i];
            end
            exp_out.push_back({sel, 1'b1, par});
            exp_pd.push_back({x != par, (npay != len) || (len == 0)});
        end else begin
            exp_ae++;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic drive_beat(input logic [7:0] d, input logic l);
        int waitc;
        waitc    = 0;
        in_valid = 1'b1;
        data_in  = d;
        in_last  = l;
        forever begin
            @(negedge clock);
            if (in_ready) break;
            waitc++;
            if (waitc > 300) begin
                n_checks++;
                n_fail++;
                $display("FAIL accept_timeout: beat %h not accepted, in_ready=%b, required 1", d, in_ready);
                break;
            end
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] hdr, input int npay, input logic [7:0] par, input int maxgap);
        drive_beat(hdr, 1'b0);
        for (int i = 0; i < npay; i++) begin
            idle($urandom_range(0, maxgap));
            drive_beat(pay[i], 1'b0);
        end
        idle($urandom_range(0, maxgap));
        drive_beat(par, 1'b1);
    endtask

    task automatic wait_idle();
        int quiet;
        int cyc;
        quiet = 0;
        cyc   = 0;
        while (quiet < 3 && cyc < 1000) begin
            @(negedge clock);
            cyc++;
            if (!dout_valid && in_ready) quiet++;
            else quiet = 0;
        end
        @(posedge clock);
        #1;
        n_checks++;
        if (quiet < 3) begin
            n_fail++;
            $display("FAIL drain_timeout: dout_valid=%b in_ready=%b, required 0/1", dout_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        in_valid = 1'b1;
        in_last  = 1'b0;
        data_in  = 8'hA5;
        idle(2);
        n_checks++;
        if ({dout_valid, in_ready, dout_last, parity_done, err, len_err, addr_err, dest_sel} !== 10'b01_0000_0000) begin
            n_fail++;
            $display("FAIL reset_in_reset: dv/rdy/last/pd/err/lerr/aerr/sel=%b, required 0100000000",
                     {dout_valid, in_ready, dout_last, parity_done, err, len_err, addr_err, dest_sel});
        end
        reset    = 1'b0;
        in_valid = 1'b0;
        @(negedge clock);
        n_checks++;
        if ({dout_valid, in_ready, parity_done, err, len_err, addr_err, dest_sel} !== 9'b01_0000_000) begin
            n_fail++;
            $display("FAIL reset_release: dv/rdy/pd/err/lerr/aerr/sel=%b, required 010000000",
                     {dout_valid, in_ready, parity_done, err, len_err, addr_err, dest_sel});
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_good_packet();
        int o0 = out_q.size();
        int e0 = exp_out.size();
        int p0 = pd_q.size();
        int q0 = exp_pd.size();
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
        model_pkt(8'h0D, 3, 8'h0D ^ 8'h11 ^ 8'h22 ^ 8'h33);
        send_pkt(8'h0D, 3, 8'h0D ^ 8'h11 ^ 8'h22 ^ 8'h33, 2);
        wait_idle();
        n_checks++;
        if (out_q.size() - o0 !== 5) begin
            n_fail++;
            $display("FAIL good_beat_count: got %0d, required 5", out_q.size() - o0);
        end
        for (int i = 0; i < exp_out.size() - e0 && o0 + i < out_q.size(); i++) begin
            n_checks++;
            if (out_q[o0 + i] !== exp_out[e0 + i]) begin
                n_fail++;
                $display("FAIL good_beat[%0d]: {sel,last,data} got %h, required %h", i, out_q[o0 + i], exp_out[e0 + i]);
            end
        end
        n_checks++;
        if (pd_q.size() - p0 !== 1 || pd_q[p0] !== exp_pd[q0]) begin
            n_fail++;
            $display("FAIL good_verdict: %0d pulses, first {err,len_err}=%b, required 1 pulse %b",
                     pd_q.size() - p0, (pd_q.size() > p0) ? pd_q[p0] : 2'bxx, exp_pd[q0]);
        end
    endtask

    task automatic test_bad_parity();
        int o0 = out_q.size();
        int e0 = exp_out.size();
        int p0 = pd_q.size();
        int q0 = exp_pd.size();
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
        model_pkt(8'h0D, 3, 8'h0C);
        send_pkt(8'h0D, 3, 8'h0C, 1);
        wait_idle();
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL bad_parity_err_hold: err got %b, required 1", err);
        end
        model_pkt(8'h0D, 3, 8'h0D);
        drive_beat(8'h0D, 1'b0);
        @(negedge clock);
        n_checks++;
        if ({err, len_err} !== 2'b00) begin
            n_fail++;
            $display("FAIL bad_parity_clear: {err,len_err} got %b, required 00", {err, len_err});
        end
        @(posedge clock);
        #1;
        for (int i = 0; i < 3; i++) drive_beat(pay[i], 1'b0);
        drive_beat(8'h0D, 1'b1);
        wait_idle();
        n_checks++;
        if (out_q.size() - o0 !== exp_out.size() - e0) begin
            n_fail++;
            $display("FAIL bad_parity_beat_count: got %0d, required %0d", out_q.size() - o0, exp_out.size() - e0);
        end
        for (int i = 0; i < exp_out.size() - e0 && o0 + i < out_q.size(); i++) begin
            n_checks++;
            if (out_q[o0 + i] !== exp_out[e0 + i]) begin
                n_fail++;
                $display("FAIL bad_parity_beat[%0d]: got %h, required %h", i, out_q[o0 + i], exp_out[e0 + i]);
            end
        end
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (p0 + i >= pd_q.size() || pd_q[p0 + i] !== exp_pd[q0 + i]) begin
                n_fail++;
                $display("FAIL bad_parity_verdict[%0d]: {err,len_err} got %b, required %b",
                         i, (p0 + i < pd_q.size()) ? pd_q[p0 + i] : 2'bxx, exp_pd[q0 + i]);
            end
        end
    endtask

    task automatic test_len_error();
        int o0 = out_q.size();
        int e0 = exp_out.size();
        int p0 = pd_q.size();
        int q0 = exp_pd.size();
        logic [7:0] par;
        for (int i = 0; i < 3; i++) pay[i] = 8'($urandom);
        par = 8'($urandom);
        model_pkt(8'h08, 3, par);
        send_pkt(8'h08, 3, par, 2);
        wait_idle();
        n_checks++;
        if (out_q.size() - o0 !== exp_out.size() - e0) begin
            n_fail++;
            $display("FAIL len_beat_count: got %0d, required %0d", out_q.size() - o0, exp_out.size() - e0);
        end
        for (int i = 0; i < exp_out.size() - e0 && o0 + i < out_q.size(); i++) begin
            n_checks++;
            if (out_q[o0 + i] !== exp_out[e0 + i]) begin
                n_fail++;
                $display("FAIL len_beat[%0d]: got %h, required %h", i, out_q[o0 + i], exp_out[e0 + i]);
            end
        end
        n_checks++;
        if (pd_q.size() - p0 !== 1 || pd_q[p0] !== exp_pd[q0]) begin
            n_fail++;
            $display("FAIL len_verdict: %0d pulses, {err,len_err}=%b, required 1 pulse %b",
                     pd_q.size() - p0, (pd_q.size() > p0) ? pd_q[p0] : 2'bxx, exp_pd[q0]);
        end
    endtask

    task automatic test_illegal_addr();
        int o0 = out_q.size();
        int e0 = exp_out.size();
        int p0 = pd_q.size();
        int a0 = ae_count;
        int d0 = dv_cycles;
        pay[0] = 8'h5A; pay[1] = 8'hC3;
        model_pkt(8'h07, 2, 8'h99);
        send_pkt(8'h07, 2, 8'h99, 1);
        wait_idle();
        n_checks++;
        if (ae_count - a0 !== 1) begin
            n_fail++;
            $display("FAIL illegal_addr_err_pulse: %0d cycles high, required 1", ae_count - a0);
        end
        n_checks++;
        if (dv_cycles - d0 !== 0 || pd_q.size() - p0 !== 0) begin
            n_fail++;
            $display("FAIL illegal_addr_dropped: dout_valid cycles %0d, parity_done %0d, required 0/0",
                     dv_cycles - d0, pd_q.size() - p0);
        end
        pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h03;
        model_pkt(8'h0E, 3, 8'h0E ^ 8'h01 ^ 8'h02 ^ 8'h03);
        send_pkt(8'h0E, 3, 8'h0E ^ 8'h01 ^ 8'h02 ^ 8'h03, 1);
        wait_idle();
        n_checks++;
        if (out_q.size() - o0 !== exp_out.size() - e0) begin
            n_fail++;
            $display("FAIL illegal_next_count: got %0d, required %0d", out_q.size() - o0, exp_out.size() - e0);
        end
        for (int i = 0; i < exp_out.size() - e0 && o0 + i < out_q.size(); i++) begin
            n_checks++;
            if (out_q[o0 + i] !== exp_out[e0 + i]) begin
                n_fail++;
                $display("FAIL illegal_next_beat[%0d]: got %h, required %h", i, out_q[o0 + i], exp_out[e0 + i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int o0 = out_q.size();
        int e0 = exp_out.size();
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
        model_pkt(8'h0D, 3, 8'h0D);
        drive_beat(8'h0D, 1'b0);
        idle(2);
        bp_force = 1'b0;
        in_valid = 1'b1;
        in_last  = 1'b0;
        data_in  = 8'h11;
        idle(1);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_ready_before_fill: in_ready got %b, required 1", in_ready);
        end
        data_in = 8'h22;
        idle(1);
        n_checks++;
        if (in_ready !== 1'b0 || dout !== 8'h11 || dout_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_after_fill: in_ready=%b dout=%h dv=%b, required 0 11 1", in_ready, dout, dout_valid);
        end
        data_in = 8'h33;
        idle(2);
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_ready_stalled: in_ready got %b, required 0", in_ready);
        end
        bp_force = 1'b1;
        idle(1);
        n_checks++;
        if (in_ready !== 1'b1 || dout !== 8'h22) begin
            n_fail++;
            $display("FAIL bp_after_drain: in_ready=%b dout=%h, required 1 22", in_ready, dout);
        end
        idle(1);
        in_valid = 1'b0;
        n_checks++;
        if (dout !== 8'h33 || dout_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_no_bubble: dout=%h dv=%b, required 33 1", dout, dout_valid);
        end
        drive_beat(8'h0D, 1'b1);
        wait_idle();
        n_checks++;
        if (out_q.size() - o0 !== 5) begin
            n_fail++;
            $display("FAIL bp_beat_count: got %0d, required 5", out_q.size() - o0);
        end
        for (int i = 0; i < exp_out.size() - e0 && o0 + i < out_q.size(); i++) begin
            n_checks++;
            if (out_q[o0 + i] !== exp_out[e0 + i]) begin
                n_fail++;
                $display("FAIL bp_beat[%0d]: got %h, required %h", i, out_q[o0 + i], exp_out[e0 + i]);
            end
        end
    endtask

    task automatic test_reset_midpacket();
        int o0;
        int e0;
        bp_force = 1'b0;
        drive_beat(8'h0D, 1'b0);
        drive_beat(8'h44, 1'b0);
        reset = 1'b1;
        idle(1);
        reset    = 1'b0;
        bp_force = 1'b1;
        n_checks++;
        if (dout_valid !== 1'b0 || in_ready !== 1'b1 || dest_sel !== 3'b000) begin
            n_fail++;
            $display("FAIL midreset_flush: dv=%b rdy=%b sel=%b, required 0 1 000", dout_valid, in_ready, dest_sel);
        end
        o0 = out_q.size();
        e0 = exp_out.size();
        pay[0] = 8'h77; pay[1] = 8'h88;
        model_pkt(8'h09, 2, 8'h09 ^ 8'h77 ^ 8'h88);
        send_pkt(8'h09, 2, 8'h09 ^ 8'h77 ^ 8'h88, 1);
        wait_idle();
        n_checks++;
        if (out_q.size() - o0 !== exp_out.size() - e0) begin
            n_fail++;
            $display("FAIL midreset_count: got %0d, required %0d", out_q.size() - o0, exp_out.size() - e0);
        end
        for (int i = 0; i < exp_out.size() - e0 && o0 + i < out_q.size(); i++) begin
            n_checks++;
            if (out_q[o0 + i] !== exp_out[e0 + i]) begin
                n_fail++;
                $display("FAIL midreset_beat[%0d]: got %h, required %h", i, out_q[o0 + i], exp_out[e0 + i]);
            end
        end
    endtask

    task automatic test_random();
        int o0 = out_q.size();
        int e0 = exp_out.size();
        int p0 = pd_q.size();
        int q0 = exp_pd.size();
        int a0 = ae_count;
        int x0 = exp_ae;
        bp_random = 1'b1;
        for (int k = 0; k < 40; k++) begin
            logic [1:0] addr;
            logic [5:0] len;
            int         npay;
            logic [7:0] hdr;
            logic [7:0] par;
            addr = 2'($urandom_range(0, 3));
            len  = 6'($urandom_range(0, 5));
            npay = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : int'(len);
            hdr  = {len, addr};
            par  = hdr;
            for (int i = 0; i < npay; i++) begin
                pay[i] = 8'($urandom);
                par    = par ^ pay[i];
            end
            if ($urandom_range(0, 3) == 0) par = par ^ 8'($urandom_range(1, 255));
            model_pkt(hdr, npay, par);
            send_pkt(hdr, npay, par, 2);
        end
        wait_idle();
        bp_random = 1'b0;
        n_checks++;
        if (out_q.size() - o0 !== exp_out.size() - e0) begin
            n_fail++;
            $display("FAIL rand_beat_count: got %0d, required %0d", out_q.size() - o0, exp_out.size() - e0);
        end
        for (int i = 0; i < exp_out.size() - e0 && o0 + i < out_q.size(); i++) begin
            n_checks++;
            if (out_q[o0 + i] !== exp_out[e0 + i]) begin
                n_fail++;
                $display("FAIL rand_beat[%0d]: got %h, required %h", i, out_q[o0 + i], exp_out[e0 + i]);
            end
        end
        n_checks++;
        if (pd_q.size() - p0 !== exp_pd.size() - q0) begin
            n_fail++;
            $display("FAIL rand_verdict_count: got %0d, required %0d", pd_q.size() - p0, exp_pd.size() - q0);
        end
        for (int i = 0; i < exp_pd.size() - q0 && p0 + i < pd_q.size(); i++) begin
            n_checks++;
            if (pd_q[p0 + i] !== exp_pd[q0 + i]) begin
                n_fail++;
                $display("FAIL rand_verdict[%0d]: {err,len_err} got %b, required %b", i, pd_q[p0 + i], exp_pd[q0 + i]);
            end
        end
        n_checks++;
        if (ae_count - a0 !== exp_ae - x0) begin
            n_fail++;
            $display("FAIL rand_addr_err: got %0d pulses, required %0d", ae_count - a0, exp_ae - x0);
        end
    endtask

    initial begin
        in_valid = 1'b0;
        in_last  = 1'b0;
        data_in  = 8'h00;
        reset    = 1'b1;
        test_reset();
        test_good_packet();
        test_bad_parity();
        test_len_error();
        test_illegal_addr();
        test_backpressure();
        test_reset_midpacket();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
